conv_layer_tile_sched: RTL and testbench



---
 rtl/conv_layer_tile_sched.sv | 215 +++++++++++++++++++++
 tb/tb_conv_layer_tile_sched.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_tile_sched.sv
// conv_layer_tile_sched
// Layer-level tile scheduler for the convolution accelerator. Walks every
// (n, m, row, col) tile of one layer (m innermost, then col, row, n), issues
// each tile to the tile datapath with a tile_start/tile_done handshake and
// inserts GAP_CYCLES idle cycles between a tile_done and the next tile_start.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   layer_start / layer_abort  start pulse (IDLE only) / abandon layer
//   layer_busy                 high from acceptance until done/abort
//   layer_done / layer_aborted one-cycle completion / abort pulses
//   tile_start / tile_done     per-tile handshake with the datapath
//   tile_base_* / tile_len_*   tile origin and clipped extent per dimension
//   tile_first_m / tile_last_m first / final input-channel slice flags
//   tile_index                 0-based ordinal of the current tile
//   layer_cycles               busy-cycle counter (only with CONV_SCHED_PERF_CNT_EN)
//
// Optional feature macro: CONV_SCHED_PERF_CNT_EN
module conv_layer_tile_sched #(
    parameter int AW         = 32,
    parameter int N          = 32,
    parameter int M          = 32,
    parameter int R          = 64,
    parameter int C          = 32,
    parameter int Tn         = 16,
    parameter int Tm         = 16,
    parameter int Tr         = 64,
    parameter int Tc         = 16,
    parameter int GAP_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          layer_start,
    input  logic          layer_abort,
    output logic          layer_busy,
    output logic          layer_done,
    output logic          layer_aborted,
    output logic          tile_start,
    input  logic          tile_done,
    output logic [AW-1:0] tile_base_n,
    output logic [AW-1:0] tile_base_m,
    output logic [AW-1:0] tile_base_row,
    output logic [AW-1:0] tile_base_col,
    output logic [AW-1:0] tile_len_n,
    output logic [AW-1:0] tile_len_m,
    output logic [AW-1:0] tile_len_row,
    output logic [AW-1:0] tile_len_col,
    output logic          tile_first_m,
    output logic          tile_last_m,
    output logic [AW-1:0] tile_index
`ifdef CONV_SCHED_PERF_CNT_EN
    ,
    output logic [AW-1:0] layer_cycles
`endif
);

    localparam logic [AW-1:0] DIM_N  = AW'(N);
    localparam logic [AW-1:0] DIM_M  = AW'(M);
    localparam logic [AW-1:0] DIM_R  = AW'(R);
    localparam logic [AW-1:0] DIM_C  = AW'(C);
    localparam logic [AW-1:0] TILE_N = AW'(Tn);
    localparam logic [AW-1:0] TILE_M = AW'(Tm);
    localparam logic [AW-1:0] TILE_R = AW'(Tr);
    localparam logic [AW-1:0] TILE_C = AW'(Tc);
    localparam logic [31:0]   GAP_LAST = 32'(GAP_CYCLES - 1);
    localparam logic [AW-1:0] ZERO_AW  = {AW{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_GAP    = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    state_t        state_r;
    state_t        next_state_s;
    logic [31:0]   gap_cnt_r;
    logic          accept_s;
    logic          abort_s;
    logic          advance_s;
    logic          load_s;
    logic          wrap_n_s, wrap_m_s, wrap_row_s, wrap_col_s;
    logic          last_tile_s;
    logic [AW-1:0] sel_n_s, sel_m_s, sel_row_s, sel_col_s;

    // Extent of a tile clipped to the remaining part of its dimension; base < dim always.
    function automatic logic [AW-1:0] clip_len(input logic [AW-1:0] tile,
                                               input logic [AW-1:0] dim,
                                               input logic [AW-1:0] base);
        logic [AW-1:0] rem;
        rem = dim - base;
        return (rem < tile) ? rem : tile;
    endfunction

    assign wrap_n_s    = (tile_base_n   + TILE_N) >= DIM_N;
    assign wrap_m_s    = (tile_base_m   + TILE_M) >= DIM_M;
    assign wrap_row_s  = (tile_base_row + TILE_R) >= DIM_R;
    assign wrap_col_s  = (tile_base_col + TILE_C) >= DIM_C;
    // Every loop sitting on its final position means the issued tile is the last one.
    assign last_tile_s = wrap_n_s & wrap_m_s & wrap_row_s & wrap_col_s;

    assign accept_s  = (state_r == ST_IDLE) & layer_start;
    assign abort_s   = (state_r != ST_IDLE) & layer_abort;
    assign advance_s = (state_r == ST_WAIT) & (next_state_s == ST_GAP);
    assign load_s    = accept_s | advance_s;

    // Next-state logic; abort overrides everything, including a coincident tile_done.
    always_comb begin
        next_state_s = state_r;
        if (abort_s) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:   next_state_s = layer_start ? ST_ISSUE : ST_IDLE;
                ST_ISSUE:  next_state_s = ST_WAIT;
                ST_WAIT: begin
                    if (tile_done) begin
                        next_state_s = last_tile_s ? ST_FINISH : ST_GAP;
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end
                ST_GAP:    next_state_s = (gap_cnt_r == GAP_LAST) ? ST_ISSUE : ST_GAP;
                ST_FINISH: next_state_s = ST_IDLE;
                default:   next_state_s = ST_IDLE;
            endcase
        end
    end

    // Next tile origin: m steps first and carries into col, col into row, row into n.
    always_comb begin
        sel_n_s   = tile_base_n;
        sel_m_s   = tile_base_m;
        sel_row_s = tile_base_row;
        sel_col_s = tile_base_col;
        if (accept_s) begin
            sel_n_s   = ZERO_AW;
            sel_m_s   = ZERO_AW;
            sel_row_s = ZERO_AW;
            sel_col_s = ZERO_AW;
        end else begin
            sel_m_s   = wrap_m_s ? ZERO_AW : tile_base_m + TILE_M;
            sel_col_s = !wrap_m_s ? tile_base_col
                      : (wrap_col_s ? ZERO_AW : tile_base_col + TILE_C);
            sel_row_s = !(wrap_m_s & wrap_col_s) ? tile_base_row
                      : (wrap_row_s ? ZERO_AW : tile_base_row + TILE_R);
            sel_n_s   = !(wrap_m_s & wrap_col_s & wrap_row_s) ? tile_base_n
                      : (wrap_n_s ? ZERO_AW : tile_base_n + TILE_N);
        end
    end

    // State, handshake pulses and tile descriptor registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            gap_cnt_r     <= 32'd0;
            layer_busy    <= 1'b0;
            layer_done    <= 1'b0;
            layer_aborted <= 1'b0;
            tile_start    <= 1'b0;
            tile_base_n   <= ZERO_AW;
            tile_base_m   <= ZERO_AW;
            tile_base_row <= ZERO_AW;
            tile_base_col <= ZERO_AW;
            tile_len_n    <= ZERO_AW;
            tile_len_m    <= ZERO_AW;
            tile_len_row  <= ZERO_AW;
            tile_len_col  <= ZERO_AW;
            tile_first_m  <= 1'b0;
            tile_last_m   <= 1'b0;
            tile_index    <= ZERO_AW;
        end else begin
            state_r       <= next_state_s;
            // Outputs are decoded from the next state so they line up with the state itself.
            layer_busy    <= (next_state_s != ST_IDLE);
            layer_done    <= (next_state_s == ST_FINISH);
            tile_start    <= (next_state_s == ST_ISSUE);
            layer_aborted <= abort_s;
            gap_cnt_r     <= (state_r == ST_GAP) ? gap_cnt_r + 32'd1 : 32'd0;
            if (load_s) begin
                tile_base_n   <= sel_n_s;
                tile_base_m   <= sel_m_s;
                tile_base_row <= sel_row_s;
                tile_base_col <= sel_col_s;
                tile_len_n    <= clip_len(TILE_N, DIM_N, sel_n_s);
                tile_len_m    <= clip_len(TILE_M, DIM_M, sel_m_s);
                tile_len_row  <= clip_len(TILE_R, DIM_R, sel_row_s);
                tile_len_col  <= clip_len(TILE_C, DIM_C, sel_col_s);
                tile_first_m  <= (sel_m_s == ZERO_AW);
                tile_last_m   <= ((sel_m_s + TILE_M) >= DIM_M);
                tile_index    <= accept_s ? ZERO_AW : tile_index + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                tile_base_n   <= tile_base_n;
                tile_index    <= tile_index;
            end
        end
    end

`ifdef CONV_SCHED_PERF_CNT_EN
    // Busy-cycle counter: cleared on acceptance, saturating, held while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            layer_cycles <= ZERO_AW;
        end else if (accept_s) begin
            layer_cycles <= ZERO_AW;
        end else if ((state_r != ST_IDLE) && (layer_cycles != {AW{1'b1}})) begin
            layer_cycles <= layer_cycles + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            layer_cycles <= layer_cycles;
        end
    end
`endif

endmodule

// File: tb/tb_conv_layer_tile_sched.sv
module tb_conv_layer_tile_sched;

    localparam int AW = 32;
    // Instance 0: default layer. Instance 1: ragged M and C, minimum gap.
    localparam int P_N[2]   = '{32, 16};
    localparam int P_M[2]   = '{32, 40};
    localparam int P_R[2]   = '{64, 8};
    localparam int P_C[2]   = '{32, 20};
    localparam int P_TN[2]  = '{16, 16};
    localparam int P_TM[2]  = '{16, 16};
    localparam int P_TR[2]  = '{64, 8};
    localparam int P_TC[2]  = '{16, 16};
    localparam int P_GAP[2] = '{4, 1};

    typedef struct {
        int n, m, row, col;
        int ln, lm, lr, lc;
        int idx;
        bit first, last;
    } tile_t;

    typedef struct {
        int k;
        int n, m, row, col, lm;
        bit first, last;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] lstart, labort, tdone;
    logic [1:0] busy, done, aborted, ts, first_m, last_m;
    logic [AW-1:0] base_n[2], base_m[2], base_r[2], base_c[2];
    logic [AW-1:0] len_n[2], len_m[2], len_r[2], len_c[2], idx[2];
`ifdef CONV_SCHED_PERF_CNT_EN
    logic [AW-1:0] lcyc[2];
`endif

    int n_checks = 0;
    int n_errors = 0;
    int busy_total[2] = '{0, 0};
    tile_t exp_q[$];
    tile_t obs_q[$];

    always #5 clk = ~clk;

    // Instance 0
    conv_layer_tile_sched #(.AW(AW), .N(32), .M(32), .R(64), .C(32), .Tn(16), .Tm(16),
                            .Tr(64), .Tc(16), .GAP_CYCLES(4)) u_dut0 (
        .clk(clk), .rst(rst), .layer_start(lstart[0]), .layer_abort(labort[0]),
        .layer_busy(busy[0]), .layer_done(done[0]), .layer_aborted(aborted[0]),
        .tile_start(ts[0]), .tile_done(tdone[0]),
        .tile_base_n(base_n[0]), .tile_base_m(base_m[0]), .tile_base_row(base_r[0]),
        .tile_base_col(base_c[0]), .tile_len_n(len_n[0]), .tile_len_m(len_m[0]),
        .tile_len_row(len_r[0]), .tile_len_col(len_c[0]), .tile_first_m(first_m[0]),
        .tile_last_m(last_m[0]), .tile_index(idx[0])
`ifdef CONV_SCHED_PERF_CNT_EN
        , .layer_cycles(lcyc[0])
`endif
    );

    // Instance 1
    conv_layer_tile_sched #(.AW(AW), .N(16), .M(40), .R(8), .C(20), .Tn(16), .Tm(16),
                            .Tr(8), .Tc(16), .GAP_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .layer_start(lstart[1]), .layer_abort(labort[1]),
        .layer_busy(busy[1]), .layer_done(done[1]), .layer_aborted(aborted[1]),
        .tile_start(ts[1]), .tile_done(tdone[1]),
        .tile_base_n(base_n[1]), .tile_base_m(base_m[1]), .tile_base_row(base_r[1]),
        .tile_base_col(base_c[1]), .tile_len_n(len_n[1]), .tile_len_m(len_m[1]),
        .tile_len_row(len_r[1]), .tile_len_col(len_c[1]), .tile_first_m(first_m[1]),
        .tile_last_m(last_m[1]), .tile_index(idx[1])
`ifdef CONV_SCHED_PERF_CNT_EN
        , .layer_cycles(lcyc[1])
`endif
    );

    // Independent count of busy cycles per instance
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (busy[k] === 1'b1) busy_total[k] <= busy_total[k] + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Reference tile list: plain nested loops, m innermost, then col, row, n.
    task automatic build_model(input int k);
        tile_t t;
        int cnt;
        exp_q.delete();
        cnt = 0;
        for (int n = 0; n < P_N[k]; n += P_TN[k])
            for (int r = 0; r < P_R[k]; r += P_TR[k])
                for (int c = 0; c < P_C[k]; c += P_TC[k])
                    for (int m = 0; m < P_M[k]; m += P_TM[k]) begin
                        t.n = n; t.m = m; t.row = r; t.col = c;
                        t.ln = min2(P_TN[k], P_N[k] - n);
                        t.lm = min2(P_TM[k], P_M[k] - m);
                        t.lr = min2(P_TR[k], P_R[k] - r);
                        t.lc = min2(P_TC[k], P_C[k] - c);
                        t.idx = cnt;
                        t.first = (m == 0);
                        t.last = (m + P_TM[k] >= P_M[k]);
                        exp_q.push_back(t);
                        cnt++;
                    end
    endtask

    task automatic step();
        @(negedge clk);
        lstart = 2'b00; labort = 2'b00; tdone = 2'b00;
    endtask

    task automatic chk_tile(input int k, input tile_t e, input string tag);
        chk({tag, "_base_n"}, base_n[k], e.n);
        chk({tag, "_base_m"}, base_m[k], e.m);
        chk({tag, "_base_row"}, base_r[k], e.row);
        chk({tag, "_base_col"}, base_c[k], e.col);
        chk({tag, "_len_n"}, len_n[k], e.ln);
        chk({tag, "_len_m"}, len_m[k], e.lm);
        chk({tag, "_len_row"}, len_r[k], e.lr);
        chk({tag, "_len_col"}, len_c[k], e.lc);
        chk({tag, "_first_m"}, first_m[k], e.first);
        chk({tag, "_last_m"}, last_m[k], e.last);
        chk({tag, "_index"}, idx[k], e.idx);
    endtask

    // Runs one layer. fixed_lat>0 fixes tile latency, else random; abort_at is a
    // 1-based tile ordinal whose tile_done carries an abort (0 = none).
    task automatic run_layer(input int k, input int fixed_lat, input int abort_at, input bit noise);
        tile_t o;
        int lat, bstart;
        bit bad;
        build_model(k);
        obs_q.delete();
        bstart = busy_total[k];
        step(); lstart[k] = 1'b1;
        step();
        for (int i = 0; i < exp_q.size(); i++) begin
            chk("tile_start", ts[k], 1'b1);
            chk("busy", busy[k], 1'b1);
            chk_tile(k, exp_q[i], "issue");
            o.n = int'(base_n[k]); o.m = int'(base_m[k]); o.row = int'(base_r[k]);
            o.col = int'(base_c[k]); o.lm = int'(len_m[k]); o.first = first_m[k];
            o.last = last_m[k]; o.ln = 0; o.lr = 0; o.lc = 0; o.idx = int'(idx[k]);
            obs_q.push_back(o);
            lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(2, 12));
            // tile_done in the tile_start cycle must be ignored
            if (noise && ($urandom_range(0, 3) == 0)) tdone[k] = 1'b1;
            for (int j = 1; j < lat; j++) begin
                step();
                chk("no_restart", ts[k], 1'b0);
                chk("stable_m", base_m[k], exp_q[i].m);
            end
            step(); tdone[k] = 1'b1;
            if (i + 1 == abort_at) labort[k] = 1'b1;
            step();
            if (i + 1 == abort_at) begin
                chk("aborted_pulse", aborted[k], 1'b1);
                chk("abort_busy", busy[k], 1'b0);
                chk("abort_done", done[k], 1'b0);
                bad = 1'b0;
                for (int g = 0; g < P_GAP[k] + 15; g++) begin
                    step();
                    if (ts[k] !== 1'b0 || done[k] !== 1'b0 || aborted[k] !== 1'b0 || busy[k] !== 1'b0) bad = 1'b1;
                end
                chk("after_abort_quiet", bad, 1'b0);
                return;
            end
            if (i == exp_q.size() - 1) begin
                chk("layer_done", done[k], 1'b1);
                chk("busy_at_done", busy[k], 1'b1);
                step();
                chk("done_pulse_end", done[k], 1'b0);
                chk("busy_end", busy[k], 1'b0);
                chk("tile_count", obs_q.size(), exp_q.size());
`ifdef CONV_SCHED_PERF_CNT_EN
                chk("layer_cycles", lcyc[k], busy_total[k] - bstart);
                if (k == 0 && fixed_lat == 10)
                    chk("layer_cycles_formula", lcyc[k], 8 * (1 + 10) + 7 * P_GAP[0] + 1);
`endif
                return;
            end
            chk("gap_done", done[k], 1'b0);
            chk("gap_start", ts[k], 1'b0);
            chk_tile(k, exp_q[i + 1], "advance");
            if (noise) begin
                tdone[k] = 1'b1;
                lstart[k] = 1'b1;
            end
            for (int g = 1; g < P_GAP[k]; g++) begin
                step();
                chk("gap_no_start", ts[k], 1'b0);
                chk("gap_stable_m", base_m[k], exp_q[i + 1].m);
            end
            step();
        end
    endtask

    vec_t vecs[11];

    initial begin
        // n, m, row, col, len_m, first, last for the documented default order and M=40 walk
        vecs[0]  = '{0, 0, 0, 0, 0, 16, 1'b1, 1'b0};
        vecs[1]  = '{0, 0, 16, 0, 0, 16, 1'b0, 1'b1};
        vecs[2]  = '{0, 0, 0, 0, 16, 16, 1'b1, 1'b0};
        vecs[3]  = '{0, 0, 16, 0, 16, 16, 1'b0, 1'b1};
        vecs[4]  = '{0, 16, 0, 0, 0, 16, 1'b1, 1'b0};
        vecs[5]  = '{0, 16, 16, 0, 0, 16, 1'b0, 1'b1};
        vecs[6]  = '{0, 16, 0, 0, 16, 16, 1'b1, 1'b0};
        vecs[7]  = '{0, 16, 16, 0, 16, 16, 1'b0, 1'b1};
        vecs[8]  = '{1, 0, 0, 0, 0, 16, 1'b1, 1'b0};
        vecs[9]  = '{1, 0, 16, 0, 0, 16, 1'b0, 1'b0};
        vecs[10] = '{1, 0, 32, 0, 0, 8, 1'b0, 1'b1};

        rst = 1'b1; lstart = 2'b00; labort = 2'b00; tdone = 2'b00;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy", busy[k], 1'b0);
            chk("rst_tile_start", ts[k], 1'b0);
            chk("rst_done", done[k], 1'b0);
            chk("rst_aborted", aborted[k], 1'b0);
            chk("rst_len_m", len_m[k], 0);
            chk("rst_first_m", first_m[k], 1'b0);
            chk("rst_index", idx[k], 0);
`ifdef CONV_SCHED_PERF_CNT_EN
            chk("rst_layer_cycles", lcyc[k], 0);
`endif
        end
        rst = 1'b0;

        // Abort has no effect while idle
        step(); labort[1] = 1'b1;
        step();
        chk("idle_abort", aborted[1], 1'b0);
        chk("idle_abort_busy", busy[1], 1'b0);

        // Default layer with 10-cycle tiles, then table comparison of the order
        run_layer(0, 10, 0, 1'b0);
        for (int v = 0; v < 8; v++) begin
            chk("tbl_n", obs_q[v].n, vecs[v].n);
            chk("tbl_m", obs_q[v].m, vecs[v].m);
            chk("tbl_col", obs_q[v].col, vecs[v].col);
            chk("tbl_row", obs_q[v].row, vecs[v].row);
        end

        // Ragged M=40 layer with random latencies and noise
        run_layer(1, 0, 0, 1'b1);
        for (int v = 8; v < 11; v++) begin
            chk("tbl40_m", obs_q[v - 8].m, vecs[v].m);
            chk("tbl40_len_m", obs_q[v - 8].lm, vecs[v].lm);
            chk("tbl40_first", obs_q[v - 8].first, vecs[v].first);
            chk("tbl40_last", obs_q[v - 8].last, vecs[v].last);
        end

        // Abort on the 3rd tile_done, then a clean restart with noise
        run_layer(0, 10, 3, 1'b0);
        run_layer(0, 0, 0, 1'b1);

        // Reset in the middle of a layer
        step(); lstart[0] = 1'b1;
        repeat (5) step();
        rst = 1'b1;
        step();
        chk("midrst_busy", busy[0], 1'b0);
        chk("midrst_tile_start", ts[0], 1'b0);
        chk("midrst_done", done[0], 1'b0);
        chk("midrst_aborted", aborted[0], 1'b0);
        chk("midrst_len_m", len_m[0], 0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("midrst_quiet", {done[0], aborted[0], busy[0], ts[0]}, 0);
        end

        // Random run on instance 1, then abort coinciding with its final tile_done
        run_layer(1, 0, 0, 1'b1);
        run_layer(1, 0, 6, 1'b0);
        run_layer(0, 0, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
